// File: rtl/aline_acq_avg.sv
// Swept-source A-line capture: triggered multi-channel acquisition with
// power-of-two sweep averaging and a valid/ready readout of the result.
module aline_acq_avg #(
    parameter int DATA_W       = 14,
    parameter int NCHAN        = 2,
    parameter int NSAMPLES     = 1170,
    parameter int ADDR_W       = 11,
    parameter int AVG_MAX_LOG2 = 3,
    parameter int DLY_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    trigger,
    input  logic                    adc_valid,
    input  logic [NCHAN*DATA_W-1:0] adc_data,
    input  logic [DLY_W-1:0]        cfg_delay,
    input  logic [2:0]              cfg_avg_log2,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [NCHAN*DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]       out_addr,
    output logic                    out_last,
    output logic [ADDR_W-1:0]       sample_pos,
    output logic                    acq_busy,
    output logic                    trig_missed
);
    localparam int ACC_W = DATA_W + AVG_MAX_LOG2;
    localparam int SW_W  = AVG_MAX_LOG2 + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_POS  = ADDR_W'(NSAMPLES - 1);
    localparam logic [2:0]        AVG_CLAMP = 3'(AVG_MAX_LOG2);

    typedef enum logic [2:0] {
        S_IDLE, S_DELAY, S_ACQ, S_WAIT, S_DUMP
    } state_t;

    state_t state_q, state_d;

    logic                    trig_q, trig_edge;
    logic [DLY_W-1:0]        dly_lat, dly_cnt;
    logic [2:0]              avg_lat, avg_cfg;
    logic [SW_W-1:0]         sweep_cnt, sweep_tgt;
    logic                    acq_wr, last_wr, frame_done;
    logic [NCHAN*ACC_W-1:0]  acc_mem [DEPTH];
    logic [NCHAN*ACC_W-1:0]  acc_old, acc_new, rd_raw;
    logic [ACC_W-1:0]        acc_ch;
    logic [NCHAN*DATA_W-1:0] rd_data, sk_data;
    logic [ADDR_W-1:0]       rd_addr, rd_v_addr, sk_addr;
    logic                    rd_done, rd_v, rd_last;
    logic                    sk_valid, sk_last, sk_nv;
    logic                    pop, out_free, issue;

    assign trig_edge  = trigger & ~trig_q;
    assign avg_cfg    = (cfg_avg_log2 > AVG_CLAMP) ? AVG_CLAMP : cfg_avg_log2;
    assign sweep_tgt  = SW_W'(1) << avg_lat;
    assign acq_wr     = (state_q == S_ACQ) && adc_valid;
    assign last_wr    = acq_wr && (sample_pos == LAST_POS);
    assign frame_done = last_wr && ((sweep_cnt + SW_W'(1)) == sweep_tgt);
    assign acq_busy   = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (trig_edge && enable)
                         state_d = (cfg_delay != '0) ? S_DELAY : S_ACQ;
            S_DELAY: if (adc_valid && dly_cnt == DLY_W'(1))
                         state_d = S_ACQ;
            S_ACQ:   if (last_wr)
                         state_d = frame_done ? S_DUMP : S_WAIT;
            S_WAIT:  if (trig_edge)
                         state_d = (dly_lat != '0) ? S_DELAY : S_ACQ;
            S_DUMP:  if (pop && out_last)
                         state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            trig_q      <= 1'b0;
            trig_missed <= 1'b0;
            dly_lat     <= '0;
            dly_cnt     <= '0;
            avg_lat     <= '0;
            sweep_cnt   <= '0;
            sample_pos  <= '0;
        end else begin
            state_q     <= state_d;
            trig_q      <= trigger;
            trig_missed <= trig_edge &&
                (state_q inside {S_DELAY, S_ACQ, S_DUMP});
            unique case (state_q)
                S_IDLE: if (trig_edge && enable) begin
                    dly_lat   <= cfg_delay;
                    dly_cnt   <= cfg_delay;
                    avg_lat   <= avg_cfg;
                    sweep_cnt <= '0;
                end
                S_DELAY: if (adc_valid) dly_cnt <= dly_cnt - 1'b1;
                S_ACQ: if (adc_valid) begin
                    if (sample_pos == LAST_POS) begin
                        sample_pos <= '0;
                        sweep_cnt  <= sweep_cnt + 1'b1;
                    end else begin
                        sample_pos <= sample_pos + 1'b1;
                    end
                end
                S_WAIT: if (trig_edge) dly_cnt <= dly_lat;
                default: ;
            endcase
        end
    end

    // First sweep of a frame overwrites, so the RAM never needs clearing
    always_comb begin
        acc_old = acc_mem[sample_pos];
        acc_new = '0;
        acc_ch  = '0;
        for (int c = 0; c < NCHAN; c++) begin
            acc_ch = (sweep_cnt == '0) ? '0 : acc_old[c*ACC_W +: ACC_W];
            acc_new[c*ACC_W +: ACC_W] =
                acc_ch + ACC_W'(adc_data[c*DATA_W +: DATA_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (acq_wr) acc_mem[sample_pos] <= acc_new;
        rd_raw <= acc_mem[rd_addr];
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NCHAN; c++)
            rd_data[c*DATA_W +: DATA_W] =
                DATA_W'(rd_raw[c*ACC_W +: ACC_W] >> avg_lat);
    end

    // Issue a read only if the skid is guaranteed free when data returns
    assign pop      = out_valid & out_ready;
    assign out_free = ~out_valid | pop;
    assign sk_nv    = sk_valid ? (out_free ? rd_v : 1'b1)
                               : (rd_v & ~out_free);
    assign issue    = (state_q == S_DUMP) & ~rd_done & ~sk_nv;
    assign rd_last  = (rd_v_addr == LAST_POS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr   <= '0;
            rd_done   <= 1'b0;
            rd_v      <= 1'b0;
            rd_v_addr <= '0;
            sk_valid  <= 1'b0;
            sk_data   <= '0;
            sk_addr   <= '0;
            sk_last   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
        end else begin
            rd_v <= issue;
            if (state_q != S_DUMP) begin
                rd_addr <= '0;
                rd_done <= 1'b0;
            end else if (issue) begin
                rd_v_addr <= rd_addr;
                rd_addr   <= rd_addr + 1'b1;
                if (rd_addr == LAST_POS) rd_done <= 1'b1;
            end
            if (out_free) begin
                if (sk_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= sk_data;
                    out_addr  <= sk_addr;
                    out_last  <= sk_last;
                end else if (rd_v) begin
                    out_valid <= 1'b1;
                    out_data  <= rd_data;
                    out_addr  <= rd_v_addr;
                    out_last  <= rd_last;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            sk_valid <= sk_nv;
            if (rd_v && (sk_valid ? out_free : ~out_free)) begin
                sk_data <= rd_data;
                sk_addr <= rd_v_addr;
                sk_last <= rd_last;
            end
        end
    end
endmodule

// File: tb/tb_aline_acq_avg.sv
// Randomised bench for aline_acq_avg with a sweep-level reference model.
module tb_aline_acq_avg;
    localparam int DW  = 14;
    localparam int NC  = 2;
    localparam int NS  = 16;
    localparam int AW  = 4;
    localparam int AM  = 3;
    localparam int DLW = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             trigger;
    logic             adc_valid;
    logic [NC*DW-1:0] adc_data;
    logic [DLW-1:0]   cfg_delay;
    logic [2:0]       cfg_avg_log2;
    logic             out_ready;
    logic             out_valid;
    logic [NC*DW-1:0] out_data;
    logic [AW-1:0]    out_addr;
    logic             out_last;
    logic [AW-1:0]    sample_pos;
    logic             acq_busy;
    logic             trig_missed;

    int errors = 0;
    int checks = 0;
    int cap [0:7][0:1][0:NS-1];

    aline_acq_avg #(
        .DATA_W(DW), .NCHAN(NC), .NSAMPLES(NS), .ADDR_W(AW),
        .AVG_MAX_LOG2(AM), .DLY_W(DLW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .trigger(trigger), .adc_valid(adc_valid), .adc_data(adc_data),
        .cfg_delay(cfg_delay), .cfg_avg_log2(cfg_avg_log2),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
        .sample_pos(sample_pos), .acq_busy(acq_busy),
        .trig_missed(trig_missed)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int dly, input int avg_cfg,
                             input int vprob, input int rprob,
                             input bit inject, input int mode,
                             input int abort_sw);
        int nsw, avg, v, cyc, beats, cnt, ep;
        int e0 [NS];
        int e1 [NS];
        bit vld, inj, rdy, trg, stall;
        logic [NC*DW-1:0] pd;
        logic [AW-1:0] pa;
        logic pl;
        avg = (avg_cfg > AM) ? AM : avg_cfg;
        nsw = 1 << avg;
        enable = 1'b1;
        cfg_delay = DLW'(dly);
        cfg_avg_log2 = 3'(avg_cfg);
        out_ready = 1'b0;
        for (int s = 0; s < nsw; s++) begin
            for (int g = 0; g < 2; g++) begin
                trigger = 1'b0;
                adc_valid = 1'($urandom);
                adc_data = {DW'($urandom), DW'($urandom)};
                step();
                checks++;
                if (out_valid !== 1'b0 || acq_busy !== (s != 0) ||
                    trig_missed !== 1'b0 || sample_pos !== '0) begin
                    errors++;
                    $display("FAIL gap s=%0d: valid=%b busy=%b missed=%b pos=%0d, want 0 %b 0 0",
                             s, out_valid, acq_busy, trig_missed, sample_pos, s != 0);
                end
            end
            trigger = 1'b1;
            adc_valid = 1'b0;
            step();
            checks++;
            if (acq_busy !== 1'b1 || trig_missed !== 1'b0 || sample_pos !== '0) begin
                errors++;
                $display("FAIL start s=%0d: busy=%b missed=%b pos=%0d, want 1 0 0",
                         s, acq_busy, trig_missed, sample_pos);
            end
            if (s == 0) begin
                enable = 1'b0;
                cfg_delay = DLW'($urandom);
                cfg_avg_log2 = 3'($urandom);
            end
            trigger = 1'b0;
            v = 0;
            cyc = 0;
            while (v < dly + NS && cyc < 1000) begin
                if (s == abort_sw && v == 6) begin
                    #2 reset_n = 1'b0;
                    #1;
                    checks++;
                    if ({out_valid, out_data, out_addr, out_last, sample_pos,
                         acq_busy, trig_missed} !== '0) begin
                        errors++;
                        $display("FAIL abort: valid=%b data=%h addr=%0d last=%b pos=%0d busy=%b missed=%b, want all 0",
                                 out_valid, out_data, out_addr, out_last,
                                 sample_pos, acq_busy, trig_missed);
                    end
                    trigger = 1'b0;
                    adc_valid = 1'b0;
                    step();
                    step();
                    reset_n = 1'b1;
                    return;
                end
                if (vprob >= 100) vld = 1'b1;
                else if (vprob == 0) vld = (cyc % 2 == 0);
                else vld = ($urandom % 100) < vprob;
                inj = inject && s == 0 && (cyc == 3 || (vld && v == dly + NS - 1));
                trigger = inj;
                adc_valid = vld;
                if (!vld) adc_data = {DW'($urandom), DW'($urandom)};
                else if (mode == 1) adc_data = {DW'(1000 + v), DW'(v)};
                else if (mode == 2) adc_data = {DW'($urandom), DW'(100 + s)};
                else adc_data = {DW'($urandom), DW'($urandom)};
                if (vld) begin
                    if (v >= dly) begin
                        cap[s][0][v-dly] = int'(adc_data[DW-1:0]);
                        cap[s][1][v-dly] = int'(adc_data[2*DW-1:DW]);
                    end
                    v++;
                end
                step();
                cyc++;
                ep = (v >= dly && v < dly + NS) ? v - dly : 0;
                checks++;
                if (sample_pos !== AW'(ep) || trig_missed !== inj ||
                    acq_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL capture s=%0d v=%0d: pos=%0d missed=%b busy=%b, want %0d %b 1",
                             s, v, sample_pos, trig_missed, acq_busy, ep, inj);
                end
            end
            trigger = 1'b0;
            if (cyc >= 1000) begin
                errors++;
                $display("FAIL capture timeout s=%0d", s);
            end
        end
        for (int i = 0; i < NS; i++) begin
            e0[i] = 0;
            e1[i] = 0;
            for (int s = 0; s < nsw; s++) begin
                e0[i] += cap[s][0][i];
                e1[i] += cap[s][1][i];
            end
            e0[i] = e0[i] >> avg;
            e1[i] = e1[i] >> avg;
        end
        beats = 0;
        cnt = 0;
        stall = 1'b0;
        pd = '0;
        pa = '0;
        pl = 1'b0;
        while (beats < NS && cnt < 400) begin
            if (stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pd ||
                    out_addr !== pa || out_last !== pl) begin
                    errors++;
                    $display("FAIL hold: valid=%b data=%h addr=%0d last=%b, want 1 %h %0d %b",
                             out_valid, out_data, out_addr, out_last, pd, pa, pl);
                end
            end
            rdy = (rprob >= 100) ? 1'b1 : (($urandom % 100) < rprob);
            trg = inject && cnt == 4;
            out_ready = rdy;
            trigger = trg;
            adc_valid = 1'($urandom);
            adc_data = {DW'($urandom), DW'($urandom)};
            if (out_valid === 1'b1 && rdy) begin
                checks++;
                if (out_addr !== AW'(beats) ||
                    out_data !== {DW'(e1[beats]), DW'(e0[beats])} ||
                    out_last !== (beats == NS - 1)) begin
                    errors++;
                    $display("FAIL beat %0d: addr=%0d data=%h last=%b, want %0d %h %b",
                             beats, out_addr, out_data, out_last, beats,
                             {DW'(e1[beats]), DW'(e0[beats])}, beats == NS - 1);
                end
                beats++;
            end
            stall = (out_valid === 1'b1) && !rdy;
            pd = out_data;
            pa = out_addr;
            pl = out_last;
            step();
            cnt++;
            checks++;
            if (trig_missed !== trg) begin
                errors++;
                $display("FAIL dump missed cnt=%0d: got %b want %b", cnt, trig_missed, trg);
            end
        end
        out_ready = 1'b0;
        trigger = 1'b0;
        checks++;
        if (beats != NS || acq_busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump end: beats=%0d busy=%b valid=%b, want %0d 0 0",
                     beats, acq_busy, out_valid, NS);
        end
        if (rprob >= 100) begin
            checks++;
            if (cnt != NS + 2) begin
                errors++;
                $display("FAIL dump latency: cycles=%0d want %0d", cnt, NS + 2);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        trigger = 1'b0;
        adc_valid = 1'b0;
        adc_data = '0;
        cfg_delay = '0;
        cfg_avg_log2 = '0;
        out_ready = 1'b0;
        step();
        step();
        checks++;
        if ({out_valid, out_data, out_addr, out_last, sample_pos,
             acq_busy, trig_missed} !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b data=%h addr=%0d last=%b pos=%0d busy=%b missed=%b, want all 0",
                     out_valid, out_data, out_addr, out_last, sample_pos,
                     acq_busy, trig_missed);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_enable_gate();
        enable = 1'b0;
        trigger = 1'b0;
        step();
        trigger = 1'b1;
        step();
        checks++;
        if (acq_busy !== 1'b0 || trig_missed !== 1'b0) begin
            errors++;
            $display("FAIL enable gate: busy=%b missed=%b, want 0 0", acq_busy, trig_missed);
        end
        trigger = 1'b0;
        step();
        checks++;
        if (acq_busy !== 1'b0 || trig_missed !== 1'b0) begin
            errors++;
            $display("FAIL enable gate after: busy=%b missed=%b, want 0 0", acq_busy, trig_missed);
        end
    endtask

    task automatic test_ramp();
        run_frame(0, 0, 100, 100, 1'b0, 1, -1);
    endtask

    task automatic test_average();
        run_frame(0, 2, 100, 100, 1'b0, 2, -1);
    endtask

    task automatic test_delay();
        run_frame(5, 0, 0, 100, 1'b0, 1, -1);
    endtask

    task automatic test_missed();
        run_frame(3, 1, 100, 100, 1'b1, 0, -1);
    endtask

    task automatic test_backpressure();
        run_frame(2, 1, 70, 50, 1'b0, 0, -1);
    endtask

    task automatic test_reset_mid();
        run_frame(0, 2, 100, 100, 1'b0, 0, 1);
        run_frame(0, 0, 100, 100, 1'b0, 0, -1);
    endtask

    task automatic test_clamp_random();
        run_frame(1, 5, 80, 60, 1'b0, 0, -1);
    endtask

    initial begin
        test_reset();
        test_enable_gate();
        test_ramp();
        test_average();
        test_delay();
        test_missed();
        test_backpressure();
        test_reset_mid();
        test_clamp_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
